axi_rd_protocol_checker: RTL and testbench

- Parametrised passive checker for one AXI4 read port (AR and R channels).
- Tracks outstanding bursts per ID and counts R beats against ARLEN.
- Flags handshake-stability, ordering, RLAST and response violations; never drives the bus.
- Instantiated beside the DUT's AXI read master in the top-level bench and bound as an assertion block.

---
 rtl/axi_chk_pkg.sv | 32 +++
 rtl/axi_chk_len_fifo.sv | 56 +++++
 rtl/axi_rd_protocol_checker.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi_rd_protocol_checker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_chk_pkg.sv
// Shared constants for the AXI4 read-channel protocol checker.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: error codes 1..ERR_N, ARBURST encodings, RRESP encodings.
package axi_chk_pkg;

  localparam int ERR_N = 9;

  // Error codes; a lower code wins when several fire in one cycle.
  localparam logic [3:0] AR_UNSTABLE   = 4'd1;
  localparam logic [3:0] R_UNSTABLE    = 4'd2;
  localparam logic [3:0] AR_OVERFLOW   = 4'd3;
  localparam logic [3:0] R_ORPHAN      = 4'd4;
  localparam logic [3:0] RLAST_EARLY   = 4'd5;
  localparam logic [3:0] RLAST_MISSING = 4'd6;
  localparam logic [3:0] INTERLEAVE    = 4'd7;
  localparam logic [3:0] BAD_BURST     = 4'd8;
  localparam logic [3:0] RESP_ERR      = 4'd9;

  // ARBURST encodings
  localparam logic [1:0] FIXED    = 2'b00;
  localparam logic [1:0] INCR     = 2'b01;
  localparam logic [1:0] WRAP     = 2'b10;
  localparam logic [1:0] RESERVED = 2'b11;

  // RRESP encodings
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi_chk_len_fifo.sv
// Per-ID FIFO of ARLEN values for bursts still awaiting their R beats.
// Latency: push visible at head/empty one cycle later; head is combinational from state.
// Backpressure: push while full and pop while empty are ignored (caller flags them).
// Ports: clk, rst (async high), push_i/din_i, pop_i, head_o (oldest entry), full_o, empty_o.
module axi_chk_len_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/axi_rd_protocol_checker.sv
// Passive AXI4 read-port checker: tracks bursts per ID and flags protocol errors.
// Latency: err_valid/err_code/err_id report one cycle after the offending edge.
// Backpressure: none; observes AR/R only and never drives the bus.
// Ports: AR*/R* bus taps, err_clr (clears err_sticky), err_valid/err_code/err_id
//        (registered report), err_sticky (bit k-1 for code k), outstanding (open bursts).
module axi_rd_protocol_checker
  import axi_chk_pkg::*;
#(
  parameter int ID_W             = 4,
  parameter int ADDR_W           = 32,
  parameter int DATA_W           = 64,
  parameter int MAX_OUT          = 4,
  parameter bit ALLOW_INTERLEAVE = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ID_W-1:0]                   ARID,
  input  logic [ADDR_W-1:0]                 ARADDR,
  input  logic [7:0]                        ARLEN,
  input  logic [2:0]                        ARSIZE,
  input  logic [1:0]                        ARBURST,
  input  logic                              ARVALID,
  input  logic                              ARREADY,
  input  logic [ID_W-1:0]                   RID,
  input  logic [DATA_W-1:0]                 RDATA,
  input  logic [1:0]                        RRESP,
  input  logic                              RLAST,
  input  logic                              RVALID,
  input  logic                              RREADY,
  input  logic                              err_clr,
  output logic                              err_valid,
  output logic [3:0]                        err_code,
  output logic [ID_W-1:0]                   err_id,
  output logic [ERR_N-1:0]                  err_sticky,
  output logic [ID_W+$clog2(MAX_OUT):0]     outstanding
);

  localparam int NID   = 2**ID_W;
  localparam int OUT_W = ID_W + $clog2(MAX_OUT) + 1;

  // Handshakes
  logic ar_hs;
  logic r_hs;
  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID & RREADY;

  // Stalled-payload capture for the stability checks
  logic              ar_pend_q;
  logic [ID_W-1:0]   ar_id_q;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [7:0]        ar_len_q;
  logic [2:0]        ar_size_q;
  logic [1:0]        ar_burst_q;
  logic              r_pend_q;
  logic [ID_W-1:0]   r_id_q;
  logic [DATA_W-1:0] r_data_q;
  logic [1:0]        r_resp_q;
  logic              r_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_pend_q  <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_pend_q   <= 1'b0;
      r_id_q     <= '0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      r_last_q   <= 1'b0;
    end else begin
      ar_pend_q <= ARVALID & ~ARREADY;
      r_pend_q  <= RVALID & ~RREADY;
      if (ARVALID && !ARREADY) begin
        ar_id_q    <= ARID;
        ar_addr_q  <= ARADDR;
        ar_len_q   <= ARLEN;
        ar_size_q  <= ARSIZE;
        ar_burst_q <= ARBURST;
      end
      if (RVALID && !RREADY) begin
        r_id_q   <= RID;
        r_data_q <= RDATA;
        r_resp_q <= RRESP;
        r_last_q <= RLAST;
      end
    end
  end

  // Per-ID ARLEN queues
  logic [NID-1:0] fifo_push;
  logic [NID-1:0] fifo_pop;
  logic [NID-1:0] fifo_full;
  logic [NID-1:0] fifo_empty;
  logic [7:0]     fifo_head [NID];
  logic [7:0]     beat_cnt_q [NID];

  // View of the burst that the current R beat belongs to
  logic       r_q_empty;
  logic [7:0] r_head;
  logic [7:0] r_cnt;
  logic       r_live;
  logic       burst_end;
  logic       ar_full;
  logic       push_ok;

  assign r_q_empty = fifo_empty[RID];
  assign r_head    = fifo_head[RID];
  assign r_cnt     = beat_cnt_q[RID];
  assign r_live    = r_hs & ~r_q_empty;
  // RLAST or the ARLEN-th beat closes the burst, whichever comes first.
  assign burst_end = r_live & (RLAST | (r_cnt == r_head));
  assign ar_full   = fifo_full[ARID];
  assign push_ok   = ar_hs & ~ar_full;

  for (genvar g = 0; g < NID; g++) begin : g_fifo
    assign fifo_push[g] = push_ok & (ARID == ID_W'(g));
    assign fifo_pop[g]  = burst_end & (RID == ID_W'(g));

    axi_chk_len_fifo #(
      .DEPTH (MAX_OUT),
      .W     (8)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push[g]),
      .pop_i   (fifo_pop[g]),
      .din_i   (ARLEN),
      .head_o  (fifo_head[g]),
      .full_o  (fifo_full[g]),
      .empty_o (fifo_empty[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NID; i++) beat_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NID; i++) begin
        if (fifo_pop[i]) begin
          beat_cnt_q[i] <= '0;
        end else if (r_live && (RID == ID_W'(i))) begin
          beat_cnt_q[i] <= beat_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Interleave lock: held by the first burst that goes multi-beat, until it ends.
  logic            lock_vld_q, lock_vld_d;
  logic [ID_W-1:0] lock_id_q,  lock_id_d;

  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    if (lock_vld_q && burst_end && (RID == lock_id_q)) begin
      lock_vld_d = 1'b0;
    end else if (!lock_vld_q && r_live && (r_cnt == 8'd0) && !burst_end) begin
      lock_vld_d = 1'b1;
      lock_id_d  = RID;
    end
  end

  // Error detection; bit k-1 corresponds to code k.
  logic [ERR_N-1:0] errs;

  always_comb begin
    errs    = '0;
    errs[0] = ar_pend_q & (~ARVALID |
              ({ARID, ARADDR, ARLEN, ARSIZE, ARBURST} !=
               {ar_id_q, ar_addr_q, ar_len_q, ar_size_q, ar_burst_q}));
    errs[1] = r_pend_q & (~RVALID |
              ({RID, RDATA, RRESP, RLAST} != {r_id_q, r_data_q, r_resp_q, r_last_q}));
    errs[2] = ar_hs & ar_full;
    errs[3] = r_hs & r_q_empty;
    errs[4] = r_live & RLAST & (r_cnt < r_head);
    errs[5] = r_live & ~RLAST & (r_cnt == r_head);
    errs[6] = ~ALLOW_INTERLEAVE & r_hs & lock_vld_q & (RID != lock_id_q);
    errs[7] = ar_hs & (ARBURST == RESERVED);
    errs[8] = r_hs & ((RRESP == SLVERR) | (RRESP == DECERR));
  end

  logic [3:0]      err_code_d;
  logic [ID_W-1:0] err_id_d;

  always_comb begin
    err_code_d = 4'd0;
    // Scan downward so the lowest-numbered active code is left standing.
    for (int k = ERR_N; k >= 1; k--) begin
      if (errs[k-1]) err_code_d = 4'(k);
    end
    err_id_d = '0;
    if ((err_code_d == AR_UNSTABLE) || (err_code_d == AR_OVERFLOW) ||
        (err_code_d == BAD_BURST)) begin
      err_id_d = ARID;
    end else if (err_code_d != 4'd0) begin
      err_id_d = RID;
    end
  end

  // Reporting and occupancy
  logic             err_valid_q;
  logic [3:0]       err_code_q;
  logic [ID_W-1:0]  err_id_q;
  logic [ERR_N-1:0] err_sticky_q, err_sticky_d;
  logic [OUT_W-1:0] out_q, out_d;

  // A new error in the clearing cycle still lands.
  assign err_sticky_d = (err_clr ? '0 : err_sticky_q) | errs;
  assign out_d        = out_q + OUT_W'(|fifo_push) - OUT_W'(|fifo_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
      err_id_q     <= '0;
      err_sticky_q <= '0;
      out_q        <= '0;
      lock_vld_q   <= 1'b0;
      lock_id_q    <= '0;
    end else begin
      err_valid_q  <= |errs;
      err_code_q   <= err_code_d;
      err_id_q     <= err_id_d;
      err_sticky_q <= err_sticky_d;
      out_q        <= out_d;
      lock_vld_q   <= lock_vld_d;
      lock_id_q    <= lock_id_d;
    end
  end

  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;
  assign err_id      = err_id_q;
  assign err_sticky  = err_sticky_q;
  assign outstanding = out_q;

endmodule

// File: tb/tb_axi_rd_protocol_checker.sv
// Bench for axi_rd_protocol_checker: one instance with interleaving allowed,
// one with it forbidden, both fed the same AR/R stimulus.
// Expected results are queued per driven cycle and compared one cycle later.
module tb_axi_rd_protocol_checker;
  import axi_chk_pkg::*;

  localparam int ID_W    = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int MAX_OUT = 4;
  localparam int OUT_W   = ID_W + $clog2(MAX_OUT) + 1;

  logic              clk;
  logic              rst;
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID, ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST, RVALID, RREADY;
  logic              err_clr;

  logic              err_valid,    err_valid_ni;
  logic [3:0]        err_code,     err_code_ni;
  logic [ID_W-1:0]   err_id,       err_id_ni;
  logic [ERR_N-1:0]  err_sticky,   err_sticky_ni;
  logic [OUT_W-1:0]  outstanding,  outstanding_ni;

  axi_rd_protocol_checker #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT), .ALLOW_INTERLEAVE(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .err_clr(err_clr), .err_valid(err_valid), .err_code(err_code), .err_id(err_id),
    .err_sticky(err_sticky), .outstanding(outstanding)
  );

  axi_rd_protocol_checker #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT), .ALLOW_INTERLEAVE(1'b0)
  ) u_dut_ni (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .err_clr(err_clr), .err_valid(err_valid_ni), .err_code(err_code_ni), .err_id(err_id_ni),
    .err_sticky(err_sticky_ni), .outstanding(outstanding_ni)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // code 0 = no error expected; -1 in outs/sticky/code_ni = not checked
  typedef struct {
    string tag;
    int    code;
    int    id;
    int    outs;
    int    sticky;
    int    code_ni;
    int    id_ni;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Outputs are registered, so each queued expectation is checked just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.tag, ".vld"},  {63'd0, err_valid}, {63'd0, e.code != 0});
      check({e.tag, ".code"}, {60'd0, err_code}, 64'(e.code));
      if (e.code != 0) check({e.tag, ".id"}, {60'd0, err_id}, 64'(e.id));
      if (e.outs >= 0) check({e.tag, ".outs"}, 64'(outstanding), 64'(e.outs));
      if (e.sticky >= 0) check({e.tag, ".sticky"}, 64'(err_sticky), 64'(e.sticky));
      if (e.code_ni >= 0) check({e.tag, ".code_ni"}, {60'd0, err_code_ni}, 64'(e.code_ni));
      if (e.code_ni > 0) check({e.tag, ".id_ni"}, {60'd0, err_id_ni}, 64'(e.id_ni));
    end
  end

  task automatic step(input string tag, input int code, input int id, input int outs,
                      input int sticky, input int code_ni, input int id_ni);
    exp_t e;
    e.tag = tag; e.code = code; e.id = id; e.outs = outs;
    e.sticky = sticky; e.code_ni = code_ni; e.id_ni = id_ni;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic quiet();
    ARVALID = 1'b0; ARREADY = 1'b0;
    RVALID  = 1'b0; RREADY  = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic go_ar(input int id, input int len, input logic [1:0] burst);
    ARVALID = 1'b1; ARREADY = 1'b1;
    ARID = 4'(id); ARLEN = 8'(len); ARBURST = burst;
    ARADDR = $urandom; ARSIZE = 3'd3;
  endtask

  task automatic go_r(input int id, input logic [1:0] resp, input bit last);
    RVALID = 1'b1; RREADY = 1'b1;
    RID = 4'(id); RRESP = resp; RLAST = last;
    RDATA = {$urandom, $urandom};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    quiet();
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = INCR;
    RID = '0; RDATA = '0; RRESP = OKAY; RLAST = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.vld",    {63'd0, err_valid}, 64'd0);
    check("rst.code",   {60'd0, err_code}, 64'd0);
    check("rst.id",     {60'd0, err_id}, 64'd0);
    check("rst.sticky", 64'(err_sticky), 64'd0);
    check("rst.outs",   64'(outstanding), 64'd0);
    rst = 1'b0;

    // Clean 4-beat burst
    quiet(); go_ar(3, 3, INCR); step("t1_ar", 0, 0, 1, 0, 0, 0);
    for (int b = 0; b < 4; b++) begin
      quiet(); go_r(3, OKAY, b == 3);
      step("t1_r", 0, 0, (b == 3) ? 0 : 1, 0, 0, 0);
    end

    // Early RLAST, then a beat with nothing open
    quiet(); go_ar(1, 3, INCR);   step("t2_ar", 0, 0, 1, 0, 0, 0);
    quiet(); go_r(1, OKAY, 1'b0); step("t2_b1", 0, 0, 1, 0, 0, 0);
    quiet(); go_r(1, OKAY, 1'b1); step("t2_early", 5, 1, 0, 16, 5, 1);
    quiet(); go_r(1, OKAY, 1'b0); step("t2_orphan", 4, 1, 0, 24, 4, 1);
    quiet(); err_clr = 1'b1;      step("t2_clr", 0, 0, 0, 0, 0, 0);

    // Queue overflow on the fifth request, then drain
    for (int k = 0; k < 5; k++) begin
      quiet(); go_ar(2, 0, FIXED);
      if (k == 4) step("t3_ovf", 3, 2, 4, 4, 3, 2);
      else        step("t3_ar", 0, 0, k + 1, 0, 0, 0);
    end
    for (int k = 0; k < 4; k++) begin
      quiet(); go_r(2, EXOKAY, 1'b1); step("t3_drain", 0, 0, 3 - k, 4, 0, 0);
    end
    quiet(); err_clr = 1'b1; step("t3_clr", 0, 0, 0, 0, 0, 0);

    // AR payload changes while stalled
    quiet();
    ARVALID = 1'b1; ARREADY = 1'b0; ARID = 4'd5; ARADDR = 32'h100;
    ARLEN = 8'd0; ARSIZE = 3'd3; ARBURST = INCR;
    step("t4_wait", 0, 0, 0, 0, 0, 0);
    ARADDR = 32'h104;
    step("t4_unstable", 1, 5, 0, 1, 1, 5);
    ARREADY = 1'b1; err_clr = 1'b1;
    step("t4_clr", 0, 0, 1, 0, 0, 0);
    quiet(); go_r(5, OKAY, 1'b1); step("t4_drain", 0, 0, 0, 0, 0, 0);

    // Interleaved two-beat bursts: only the no-interleave instance complains
    quiet(); go_ar(0, 1, INCR);   step("t5_ar0", 0, 0, 1, 0, 0, 0);
    quiet(); go_ar(1, 1, INCR);   step("t5_ar1", 0, 0, 2, 0, 0, 0);
    quiet(); go_r(0, OKAY, 1'b0); step("t5_r0", 0, 0, 2, 0, 0, 0);
    quiet(); go_r(1, OKAY, 1'b0); step("t5_il", 0, 0, 2, 0, 7, 1);
    quiet(); go_r(0, OKAY, 1'b1); step("t5_r0l", 0, 0, 1, 0, 0, 0);
    quiet(); go_r(1, OKAY, 1'b1); step("t5_r1l", 0, 0, 0, 0, 0, 0);

    // Reserved burst and error response in one cycle, plus push/pop balance
    quiet(); go_ar(3, 0, INCR); step("t6_ar", 0, 0, 1, 0, 0, 0);
    quiet(); go_ar(4, 0, RESERVED); go_r(3, SLVERR, 1'b1);
    step("t6_both", 8, 4, 1, 384, 8, 4);
    quiet(); go_r(4, OKAY, 1'b1);   step("t6_drain", 0, 0, 0, 384, 0, 0);
    quiet(); go_ar(4, 0, WRAP);     step("t6_ar2", 0, 0, 1, 384, 0, 0);
    quiet(); go_r(4, DECERR, 1'b1); step("t6_decerr", 9, 4, 0, 384, 9, 4);

    // Same-ID push and pop in one cycle
    quiet(); go_ar(6, 0, INCR); step("t7_ar", 0, 0, 1, 384, 0, 0);
    quiet(); go_ar(6, 0, INCR); go_r(6, OKAY, 1'b1); step("t7_pp", 0, 0, 1, 384, 0, 0);
    quiet(); go_r(6, OKAY, 1'b1); step("t7_drain", 0, 0, 0, 384, 0, 0);

    // Missing RLAST on the final beat
    quiet(); go_ar(8, 1, INCR);   step("t8_ar", 0, 0, 1, 384, 0, 0);
    quiet(); go_r(8, OKAY, 1'b0); step("t8_b1", 0, 0, 1, 384, 0, 0);
    quiet(); go_r(8, OKAY, 1'b0); step("t8_miss", 6, 8, 0, 416, 6, 8);

    // Reset mid-burst discards tracking
    quiet(); go_ar(7, 3, INCR);   step("t9_ar", 0, 0, 1, 416, 0, 0);
    quiet(); go_r(7, OKAY, 1'b0); step("t9_b1", 0, 0, 1, 416, 0, 0);
    quiet(); rst = 1'b1;
    #1;
    check("t9_rst.outs",   64'(outstanding), 64'd0);
    check("t9_rst.sticky", 64'(err_sticky), 64'd0);
    check("t9_rst.vld",    {63'd0, err_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet(); go_r(7, OKAY, 1'b0); step("t9_orphan", 4, 7, 0, 8, 4, 7);

    // R valid withdrawn while stalled
    quiet(); RVALID = 1'b1; RREADY = 1'b0; RID = 4'd9; RLAST = 1'b0;
    step("t10_wait", 0, 0, 0, 8, 0, 0);
    quiet(); step("t10_unstable", 2, 9, 0, 10, 2, 9);
    quiet(); step("t10_idle", 0, 0, 0, 10, 0, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
